multichannel_deglitch: RTL and testbench
========================================

// Module: multichannel_deglitch
// PURPOSE
//  N-channel synchroniser plus bipolar deglitch filter for slow board inputs (limit switches, fault lines, encoder index).
//  Each channel: SYNC_STAGES-flop synchroniser, then a qualifying counter gated by a shared clk_en tick.
//  Rise/fall delays set at run time; filter mode set per channel. Also reports edge pulses and sticky glitch flags.
//  Sits between the input pads and the register/interrupt logic.
// PARAMETERS
//  CHANNELS        8    number of independent channels (1..32)
//  DELAY_WIDTH     8    width of delay_rise/delay_fall and of each channel counter
//  SYNC_STAGES     2    synchroniser depth (>=2)
//  DEFAULT_OUTPUT  '0   CHANNELS-bit vector: reset value of sync chain and out, per channel
// PORTS
//  reset         in   1             asynchronous, active-high
//  clk           in   1             clock
//  clk_en        in   1             filter tick; counters and out advance only when high
//  delay_rise    in   DELAY_WIDTH   ticks to qualify 0->1
//  delay_fall    in   DELAY_WIDTH   ticks to qualify 1->0
//  mode          in   2*CHANNELS    per-channel mode [2i+1:2i]: 0 bypass, 1 bipolar, 2 rise-filter, 3 fall-filter
//  in            in   CHANNELS      raw asynchronous inputs
//  glitch_clear  in   CHANNELS      per-channel clear of glitch_flag
//  out           out  CHANNELS      filtered level
//  rise_pulse    out  CHANNELS      1-clk pulse when out goes 0->1
//  fall_pulse    out  CHANNELS      1-clk pulse when out goes 1->0
//  glitch_flag   out  CHANNELS      sticky: an unqualified transition was aborted
// BEHAVIOUR
//  Reset:
//   - sync chain[i] and out[i] = DEFAULT_OUTPUT[i]
//   - counters = 0
//   - rise_pulse, fall_pulse, glitch_flag = 0
//  Synchroniser: shifts every clk regardless of clk_en. s[i] = last stage.
//  Filter (clk_en=1, per channel): D = delay_rise if out=0, else delay_fall.
//   - s==out: counter<=0. If counter!=0, set glitch_flag (aborted transition).
//   - s!=out, filtered direction: if counter>=D, then out<=s and counter<=0.
//     Otherwise counter<=counter+1, saturating at all-ones.
//   - s!=out, unfiltered direction: out<=s immediately, counter<=0.
//  Filtered direction by mode:
//   - bipolar: both directions.
//   - rise-filter: 0->1 only.
//   - fall-filter: 1->0 only.
//   - bypass: neither; counter held 0, glitch never set.
//  Latency:
//   - filtered edge: out flips on the (D+1)th consecutive clk_en tick with s!=out. D=0 gives 1 tick.
//   - pad to s: SYNC_STAGES clks.
//  clk_en=0: counters, out and glitch_flag hold. rise_pulse/fall_pulse are 0.
//  Pulses: asserted in the same cycle out changes, for exactly one clk.
//  D changed mid-qualification: the new value applies on the next tick. If counter>=new D, out flips on that tick.
//  Mode changed mid-qualification: the new mode applies on the next tick. The counter is not reset.
//  glitch_clear and a glitch set in the same cycle: set wins.
//  Channels are fully independent. No cross-channel interaction except the shared delays and clk_en.
//  Reset mid-qualification: all state returns to reset values at once. No pulse is generated.
// TESTING
//  1) clk_en=1 every clk, bipolar, delay_rise=3. in[0] 0->1 held.
//     -> out[0]=1 exactly SYNC_STAGES+4 clks after the edge; rise_pulse[0] high 1 clk; glitch_flag=0.
//  2) Same setup, in[0] high 3 ticks then low.
//     -> out[0] stays 0; glitch_flag[0]=1 until glitch_clear[0], then 0.
//  3) clk_en every 4th clk, delay_fall=2, out=1, in->0.
//     -> out falls on the 3rd enabled tick after sync; no change on non-enabled clks; fall_pulse width 1 clk.
//  4) mode=2 (rise-filter), delay_rise=5: 1-tick low glitch while out=1.
//     -> out drops immediately, fall_pulse=1. 0->1 still takes 6 ticks.
//  5) Bypass on ch1, bipolar on ch0, same stimulus.
//     -> ch1 follows s every tick, ch0 delayed; glitch_flag[1] never set.
//  6) Assert reset with counter=2 of 3; DEFAULT_OUTPUT[0]=1.
//     -> out[0]=1 immediately, pulses 0, counter 0. After release, qualification restarts from 0.

Source files
------------

// File: rtl/multichannel_deglitch.sv
// multichannel_deglitch: per-channel synchroniser plus tick-gated bipolar deglitch filter with edge pulses and sticky glitch flags
module multichannel_deglitch #(
  parameter int CHANNELS = 8,
  parameter int DELAY_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] DEFAULT_OUTPUT = '0
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   clk_en,
  input  logic [DELAY_WIDTH-1:0] delay_rise,
  input  logic [DELAY_WIDTH-1:0] delay_fall,
  input  logic [2*CHANNELS-1:0]  mode,
  input  logic [CHANNELS-1:0]    in,
  input  logic [CHANNELS-1:0]    glitch_clear,
  output logic [CHANNELS-1:0]    out,
  output logic [CHANNELS-1:0]    rise_pulse,
  output logic [CHANNELS-1:0]    fall_pulse,
  output logic [CHANNELS-1:0]    glitch_flag
);
  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DELAY_WIDTH-1:0] cnt, cnt_nxt, d;
    logic [1:0] m;
    logic s, filt, flip, glitch_set, out_q, rise_q, fall_q, glitch_q;
    always_comb begin
      m = mode[2*g +: 2];
      s = sync_q[SYNC_STAGES-1];
      d = out_q ? delay_fall : delay_rise;
      filt = (m == 2'd1) || (m == (out_q ? 2'd3 : 2'd2));
      flip = (s != out_q) && (!filt || cnt >= d);
      // a counter left non-zero when the input returns means a transition was abandoned
      glitch_set = (m != 2'd0) && (s == out_q) && (cnt != '0);
      cnt_nxt = (s == out_q || flip || m == 2'd0) ? '0 : (&cnt ? cnt : cnt + 1'b1);
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sync_q   <= {SYNC_STAGES{DEFAULT_OUTPUT[g]}};
        cnt      <= '0;
        out_q    <= DEFAULT_OUTPUT[g];
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[g]};
        rise_q <= clk_en && flip && !out_q;
        fall_q <= clk_en && flip && out_q;
        if (clk_en) begin
          cnt      <= cnt_nxt;
          out_q    <= out_q ^ flip;
          glitch_q <= glitch_set || (glitch_q && !glitch_clear[g]);
        end
      end
    assign out[g] = out_q;
    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
    assign glitch_flag[g] = glitch_q;
  end
endmodule

// File: tb/tb_multichannel_deglitch.sv
// tb_multichannel_deglitch: directed checks of sync latency, qualification, modes, pulses, glitch flags and reset
module tb_multichannel_deglitch;
  logic reset, clk, clk_en;
  logic [7:0] delay_rise, delay_fall, mode;
  logic [3:0] din, glitch_clear, out, rise_pulse, fall_pulse, glitch_flag;
  int n_cmp = 0, n_bad = 0;

  multichannel_deglitch #(.CHANNELS(4), .DELAY_WIDTH(8), .SYNC_STAGES(2), .DEFAULT_OUTPUT(4'b0001)) dut (
    .reset(reset), .clk(clk), .clk_en(clk_en), .delay_rise(delay_rise), .delay_fall(delay_fall),
    .mode(mode), .in(din), .glitch_clear(glitch_clear), .out(out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .glitch_flag(glitch_flag)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; clk_en = 1; delay_rise = 3; delay_fall = 3; mode = 8'h55;
    din = 4'b0001; glitch_clear = 0;
    tick(3);
    check("rst_out", out, 4'b0001);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    check("rst_glitch", glitch_flag, 0);
    reset = 0;
    tick(10);
    check("idle_out", out, 4'b0001);
    din = 0;
    tick(12);
    check("setup_out", out, 0);
    check("setup_glitch", glitch_flag, 0);
    // 1) rise with delay 3: out flips on the 6th clk after the pad edge
    din[0] = 1;
    tick(5);
    check("t1_out_early", out, 0);
    tick(1);
    check("t1_out", out, 4'b0001);
    check("t1_rise", rise_pulse, 4'b0001);
    tick(1);
    check("t1_rise_end", rise_pulse, 0);
    check("t1_glitch", glitch_flag, 0);
    // 2) three-tick high glitch is rejected and flagged
    din[0] = 0;
    tick(10);
    check("t2_pre_out", out, 0);
    din[0] = 1;
    tick(3);
    din[0] = 0;
    tick(10);
    check("t2_out", out, 0);
    check("t2_glitch", glitch_flag, 4'b0001);
    check("t2_rise", rise_pulse, 0);
    glitch_clear[0] = 1;
    tick(1);
    glitch_clear[0] = 0;
    check("t2_cleared", glitch_flag, 0);
    // 3) clk_en every 4th clk, delay_fall 2: falls on the 3rd tick after sync
    din[0] = 1;
    tick(10);
    check("t3_pre_out", out, 4'b0001);
    delay_fall = 2;
    din[0] = 0;
    for (int k = 1; k <= 16; k++) begin
      clk_en = (k % 4 == 0);
      tick(1);
      check($sformatf("t3_out_%0d", k), out[0], k < 12);
      check($sformatf("t3_fall_%0d", k), fall_pulse[0], k == 12);
    end
    clk_en = 1; delay_fall = 3;
    // 4) rise-filter: low glitch passes at once, re-rise takes 6 ticks
    mode = 8'h56; delay_rise = 5;
    din[0] = 1;
    tick(10);
    check("t4_pre_out", out, 4'b0001);
    din[0] = 0;
    tick(1);
    din[0] = 1;
    tick(1);
    check("t4_hold", out, 4'b0001);
    tick(1);
    check("t4_drop", out, 0);
    check("t4_fall", fall_pulse, 4'b0001);
    tick(5);
    check("t4_wait", out, 0);
    tick(1);
    check("t4_rise_out", out, 4'b0001);
    check("t4_rise", rise_pulse, 4'b0001);
    check("t4_glitch", glitch_flag, 0);
    mode = 8'h55; delay_rise = 3;
    // 5) ch1 bypass, ch0 bipolar, same 2-clk pulse
    mode = 8'h51;
    din = 0;
    tick(10);
    check("t5_pre_out", out, 0);
    din[1:0] = 2'b11;
    tick(2);
    din[1:0] = 2'b00;
    check("t5_e2", out, 0);
    tick(1);
    check("t5_e3_out", out, 4'b0010);
    check("t5_e3_rise", rise_pulse, 4'b0010);
    tick(1);
    check("t5_e4_out", out, 4'b0010);
    check("t5_e4_rise", rise_pulse, 0);
    tick(1);
    check("t5_e5_out", out, 0);
    check("t5_e5_fall", fall_pulse, 4'b0010);
    tick(3);
    check("t5_glitch", glitch_flag, 4'b0001);
    glitch_clear = 4'b1111;
    tick(1);
    glitch_clear = 0;
    check("t5_cleared", glitch_flag, 0);
    mode = 8'h55;
    // 6) async reset mid-qualification, then qualification restarts from zero
    din[0] = 1;
    tick(4);
    check("t6_pre_out", out, 0);
    reset = 1;
    din[0] = 0;
    #1;
    check("t6_async_out", out, 4'b0001);
    check("t6_async_rise", rise_pulse, 0);
    check("t6_async_fall", fall_pulse, 0);
    tick(2);
    reset = 0;
    tick(5);
    check("t6_restart_hold", out, 4'b0001);
    tick(1);
    check("t6_restart_out", out, 0);
    check("t6_restart_fall", fall_pulse, 4'b0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
